// File: rtl/sseg_pkg.sv
`timescale 1ns/1ps
// Shared glyph table, digit count and frame FSM state type for the
// seven-segment display decoder.
package sseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment patterns, bit6=A .. bit0=G, 1=lit
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/sseg_pattern_decode.sv
`timescale 1ns/1ps
// Combinational glyph decoder: 7-bit segment pattern -> hex nibble.
// Unrecognised patterns decode to 0 with the invalid flag raised.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);

  // Table lookup of the sixteen legal glyphs
  always_comb begin
    nibble  = '0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_decoder.sv
`timescale 1ns/1ps
// Multiplexed seven-segment display snooper: synchronises the segment and
// digit-strobe lines, captures each digit once it has been stable long
// enough, and presents completed four-digit frames over valid/ready.
module sseg_decoder
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic                    sign_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    neg,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  localparam int unsigned SW      = NUM_DIGITS + 8;
  localparam logic [7:0]  CAP_CNT = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0] sync1_q, sync1_d;
  logic [SW-1:0] sync2_q, sync2_d;
  logic [SW-1:0] prev_q,  prev_d;
  logic [7:0]    cnt_q,   cnt_d;

  logic [4*NUM_DIGITS-1:0] wnib_q,  wnib_d;
  logic [NUM_DIGITS-1:0]   werr_q,  werr_d;
  logic [NUM_DIGITS-1:0]   wmask_q, wmask_d;
  logic                    wsign_q, wsign_d;

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic                    neg_q,   neg_d;
  logic [NUM_DIGITS-1:0]   err_q,   err_d;
  state_e                  state_q, state_d;

  logic                  capture;
  logic                  sel_onehot;
  logic [NUM_DIGITS-1:0] cap_sel;
  logic [6:0]            cap_seg;
  logic                  cap_sign;
  logic [3:0]            dec_nib;
  logic                  dec_inv;
  logic                  load;

  // prev_q holds the sample the stability count refers to, so captures
  // take their data from it rather than from the live synchroniser output.
  assign cap_sel  = prev_q[SW-1 -: NUM_DIGITS];
  assign cap_seg  = prev_q[7:1];
  assign cap_sign = prev_q[0];

  sseg_pattern_decode u_decode (
    .pattern (cap_seg),
    .nibble  (dec_nib),
    .invalid (dec_inv)
  );

  // Synchroniser, history register and saturating stability counter
  always_comb begin
    sync1_d    = {dig_sel, seg_in, sign_in};
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    cnt_d      = '0;
    if (sync2_q == prev_q) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
    capture    = (cnt_q == CAP_CNT);
    sel_onehot = (cap_sel != '0) && ((cap_sel & (cap_sel - 1'b1)) == '0);
  end

  // Frame FSM, output load and working-buffer capture
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    neg_d   = neg_q;
    err_d   = err_q;
    wnib_d  = wnib_q;
    werr_d  = werr_q;
    wsign_d = wsign_q;
    load    = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (wmask_q == '1) begin
          load    = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (wmask_q == '1) load = 1'b1;
          else               state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    if (load) begin
      value_d = wnib_q;
      neg_d   = wsign_q;
      err_d   = werr_q;
    end

    // Clear first so a simultaneous capture lands in the fresh mask
    wmask_d = load ? '0 : wmask_q;

    if (capture && sel_onehot) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cap_sel[i]) begin
          wnib_d[4*i +: 4] = dec_nib;
          werr_d[i]        = dec_inv;
          wmask_d[i]       = 1'b1;
          if (i == NUM_DIGITS - 1) wsign_d = cap_sign;
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      wnib_q  <= '0;
      werr_q  <= '0;
      wmask_q <= '0;
      wsign_q <= 1'b0;
      value_q <= '0;
      neg_q   <= 1'b0;
      err_q   <= '0;
      state_q <= ST_COLLECT;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      wnib_q  <= wnib_d;
      werr_q  <= werr_d;
      wmask_q <= wmask_d;
      wsign_q <= wsign_d;
      value_q <= value_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign value     = value_q;
  assign neg       = neg_q;
  assign digit_err = err_q;

endmodule

// File: doc/sseg_decoder.md
SSEG_DECODER -- requirements
Module: sseg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical synchronised samples required before a digit is captured; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the only clock; all flops rise-edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port seg_in, input, 7, segment pattern with bit6=A through bit0=G, 1=lit.
REQ-005 SHALL have port sign_in, input, 1, minus-sign segment, 1=lit.
REQ-006 SHALL have port dig_sel, input, 4, one-hot digit strobe, bit0=least significant digit.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the frame.
REQ-008 SHALL have port out_valid, output, 1, decoded frame available.
REQ-009 SHALL have port value, output, 16, decoded digits, digit i in bits [4i+3:4i].
REQ-010 SHALL have port neg, output, 1, sign captured with digit 3.
REQ-011 SHALL have port digit_err, output, 4, bit i set when digit i pattern was not a legal glyph.

Function
REQ-012 SHALL pass seg_in, sign_in, dig_sel through a two-flop synchroniser before any other use.
REQ-013 SHALL compare synchronised {dig_sel,seg,sign} to the previous cycle; equal -> 8-bit stability counter increments, saturating; different -> counter clears to 0.
REQ-014 SHALL issue exactly one capture per stable window, on the cycle the counter reaches STABLE_CYCLES-1.
REQ-015 SHALL ignore a capture when dig_sel is zero or not one-hot (no buffer change).
REQ-016 SHALL decode glyphs: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=73,A=77,B=1F,C=4E,D=3D,E=4F,F=47 (hex of seg bits).
REQ-017 SHALL decode any other pattern to nibble 0 and set the digit's error bit in the working buffer.
REQ-018 SHALL store a capture into working nibble i, working error bit i and set working mask bit i; digit 3 capture also stores sign.
REQ-019 SHALL overwrite a digit recaptured before its frame completes.
REQ-020 SHALL implement FSM COLLECT/PRESENT; COLLECT with working mask 4'hF -> load output regs, clear mask, go PRESENT; out_valid=1 exactly in PRESENT.
REQ-021 SHALL hold value, neg, digit_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL keep collecting into the working buffer during PRESENT.
REQ-023 SHALL, on handshake (out_valid&out_ready) with working mask full, load the new frame, clear mask, stay PRESENT (out_valid stays 1); otherwise go COLLECT.
REQ-024 SHALL let a capture coincident with a mask clear set its bit in the freshly cleared mask.
REQ-025 SHALL assert out_valid the cycle after the capture completing the mask.

Reset
REQ-026 SHALL, on rst, clear synchroniser, counter, working buffer and mask, set FSM COLLECT, and drive out_valid=0, value=0, neg=0, digit_err=0.
REQ-027 SHALL discard any partial or presented frame when rst asserts mid-operation; first frame after reset requires all four fresh captures.

Structure
REQ-028 SHALL place glyph constants SEG_0..SEG_F, NUM_DIGITS=4 and the FSM state type in shared package sseg_pkg.
REQ-029 SHALL use one combinational sub-module sseg_pattern_decode (7-bit pattern -> nibble, invalid flag).

Verification
REQ-030 SHALL cover: digits 0..3 held 6 cycles each as 30,79,33,5B (1,3,4,5), sign_in=1 on digit 3 -> out_valid, value=16'h5431, neg=1, digit_err=0.
REQ-031 SHALL cover: digit 2 pattern 7'h01 -> value[11:8]=0, digit_err=4'b0100.
REQ-032 SHALL cover: pattern stable only STABLE_CYCLES-1 cycles, and dig_sel=4'b0011 -> no capture, out_valid stays 0.
REQ-033 SHALL cover: out_ready=0 for 20 cycles while next frame 16'hBEEF completes -> outputs hold first frame; out_ready pulse -> 16'hBEEF presented next cycle, out_valid never drops.
REQ-034 SHALL cover: rst pulse after three captures -> all outputs 0; next frame needs four captures.
REQ-035 SHALL cover: all 16 glyphs cycled through digit 0 -> each decodes to its index.
